// File: rtl/rib_pkg.sv
// Shared types and constants for the rib bus arbiter.
package rib_pkg;
  localparam int RIB_N_MASTER = 4;
  localparam int RIB_QUANTUM  = 8;

  typedef logic [1:0] mid_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/rib_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning from ptr_i upward, mod 4.
module rr_pick
  import rib_pkg::*;
(
  input  logic [RIB_N_MASTER-1:0] req_i,
  input  mid_t                    ptr_i,
  output mid_t                    win_o,
  output logic                    vld_o
);

  mid_t idx;

  // Scan highest offset first so the lowest offset from ptr_i is the last writer.
  always_comb begin
    win_o = '0;
    vld_o = 1'b0;
    idx   = '0;
    for (int i = RIB_N_MASTER - 1; i >= 0; i--) begin
      idx = ptr_i + mid_t'(i);
      if (req_i[idx]) begin
        win_o = idx;
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rib_arbiter.sv
// Registered round-robin bus arbiter for four rib masters, with core stall flag.
// Optional quantum-based preemption is compiled in with `define RIB_ARB_PREEMPT_EN.
module rib_arbiter
  import rib_pkg::*;
#(
  parameter int N_MASTER = RIB_N_MASTER,
  parameter int QUANTUM  = RIB_QUANTUM
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_MASTER-1:0] req_i,
  output logic [N_MASTER-1:0] gnt_o,
  output logic [1:0]          gnt_id_o,
  output logic                gnt_valid_o,
  output logic                hold_flag_o,
  output logic                preempt_o
);

  if (QUANTUM < 1) begin : g_quantum_chk
    $error("rib_arbiter: QUANTUM must be >= 1");
  end

  state_t              state_q, state_d;
  mid_t                owner_q, owner_d;
  mid_t                ptr_q,   ptr_d;
  logic [N_MASTER-1:0] gnt_q,   gnt_d;

  logic [N_MASTER-1:0] pick_req;
  mid_t                pick_win;
  logic                pick_vld;
  logic                owner_rel;
  logic                preempt;

`ifdef RIB_ARB_PREEMPT_EN
  localparam int CW = $clog2(QUANTUM + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          expire;
`endif

  // The current owner never competes against itself on handover or preemption.
  assign pick_req = (state_q == BUSY) ? (req_i & ~gnt_q) : req_i;

  rr_pick u_pick (
    .req_i (pick_req),
    .ptr_i (ptr_q),
    .win_o (pick_win),
    .vld_o (pick_vld)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    preempt   = 1'b0;
    owner_rel = ~req_i[owner_q];
`ifdef RIB_ARB_PREEMPT_EN
    cnt_d     = cnt_q;
    expire    = (cnt_q == CW'(QUANTUM));
    // A release coinciding with expiry is an ordinary handover, not a preemption.
    preempt   = (state_q == BUSY) && !owner_rel && expire && pick_vld;
`endif

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = BUSY;
          owner_d = pick_win;
          gnt_d   = {{(N_MASTER-1){1'b0}}, 1'b1} << pick_win;
          ptr_d   = pick_win + 2'd1;
`ifdef RIB_ARB_PREEMPT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        if (owner_rel || preempt) begin
          if (pick_vld) begin
            owner_d = pick_win;
            gnt_d   = {{(N_MASTER-1){1'b0}}, 1'b1} << pick_win;
            ptr_d   = pick_win + 2'd1;
`ifdef RIB_ARB_PREEMPT_EN
            cnt_d   = '0;
`endif
          end else begin
            state_d = IDLE;
            owner_d = '0;
            gnt_d   = '0;
          end
        end
`ifdef RIB_ARB_PREEMPT_EN
        else if (!expire) begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      default: begin
        state_d = IDLE;
        owner_d = '0;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
    end
  end

`ifdef RIB_ARB_PREEMPT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  assign gnt_o       = gnt_q;
  assign gnt_id_o    = owner_q;
  assign gnt_valid_o = |gnt_q;
  assign hold_flag_o = req_i[0] & ~gnt_q[0];
  assign preempt_o   = preempt;

endmodule

// File: tb/tb_rib_arbiter.sv
// Self-checking bench for rib_arbiter: directed table, corner sequences, and random traffic vs a reference model.
module tb_rib_arbiter;
  import rib_pkg::*;

  localparam int Q = RIB_QUANTUM;
`ifdef RIB_ARB_PREEMPT_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_i;
  logic [3:0] gnt_o;
  logic [1:0] gnt_id_o;
  logic       gnt_valid_o, hold_flag_o, preempt_o;

  always #5 clk = ~clk;

  rib_arbiter #(.N_MASTER(4), .QUANTUM(Q)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .gnt_id_o    (gnt_id_o),
    .gnt_valid_o (gnt_valid_o),
    .hold_flag_o (hold_flag_o),
    .preempt_o   (preempt_o)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: owner index (-1 = none), rotating priority start, cycles held.
  int m_owner, m_ptr, m_held;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic       hold;
  } vec_t;
  vec_t tbl[17];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] outs();
    return {gnt_o, gnt_id_o, gnt_valid_o, hold_flag_o, preempt_o};
  endfunction

  function automatic void model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
  endfunction

  function automatic bit model_preempt(input logic [3:0] r);
    logic [3:0] others;
    others = r;
    if (m_owner < 0) return 1'b0;
    others[m_owner] = 1'b0;
    return PRE && r[m_owner] && (m_held >= Q) && (others != 4'b0);
  endfunction

  function automatic logic [8:0] model_expect(input logic [3:0] r);
    logic [3:0] g;
    logic [1:0] id;
    g  = 4'b0;
    id = 2'd0;
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1;
      id = 2'(m_owner);
    end
    return {g, id, (m_owner >= 0), (r[0] && m_owner != 0), model_preempt(r)};
  endfunction

  function automatic void model_step(input logic [3:0] r);
    bit take;
    int w;
    take = (m_owner < 0) || !r[m_owner] || model_preempt(r);
    if (take) begin
      w = -1;
      for (int i = 0; i < 4; i++) begin
        int c;
        c = (m_ptr + i) % 4;
        if (w < 0 && r[c] && c != m_owner) w = c;
      end
      if (w >= 0) begin
        m_owner = w;
        m_ptr   = (w + 1) % 4;
        m_held  = 0;
      end else begin
        m_owner = -1;
      end
    end else begin
      m_held++;
    end
  endfunction

  // One clock cycle: drive req in the low phase, compare, then advance the model.
  task automatic cycle(input logic [3:0] r, input bit chk_model);
    @(negedge clk);
    req_i = r;
    #1;
    if (chk_model) check("model", 16'(outs()), 16'(model_expect(r)));
    model_step(r);
  endtask

  initial begin
    // round-robin order with one-cycle releases, then the stall-flag sequence
    tbl[0]  = '{4'b1111, 4'b0000, 1'b1};
    tbl[1]  = '{4'b1110, 4'b0001, 1'b0};
    tbl[2]  = '{4'b1111, 4'b0010, 1'b1};
    tbl[3]  = '{4'b1101, 4'b0010, 1'b1};
    tbl[4]  = '{4'b1111, 4'b0100, 1'b1};
    tbl[5]  = '{4'b1011, 4'b0100, 1'b1};
    tbl[6]  = '{4'b1111, 4'b1000, 1'b1};
    tbl[7]  = '{4'b0111, 4'b1000, 1'b1};
    tbl[8]  = '{4'b1111, 4'b0001, 1'b0};
    tbl[9]  = '{4'b0000, 4'b0001, 1'b0};
    tbl[10] = '{4'b0100, 4'b0000, 1'b0};
    tbl[11] = '{4'b0101, 4'b0100, 1'b1};
    tbl[12] = '{4'b0101, 4'b0100, 1'b1};
    tbl[13] = '{4'b0001, 4'b0100, 1'b1};
    tbl[14] = '{4'b0001, 4'b0001, 1'b0};
    tbl[15] = '{4'b0000, 4'b0001, 1'b0};
    tbl[16] = '{4'b0000, 4'b0000, 1'b0};

    rst   = 1'b1;
    req_i = 4'b1111;
    model_reset();
    @(posedge clk);
    #1;
    check("reset_vals", 16'(outs()), 16'(9'b0000_00_0_1_0));
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      req_i = tbl[i].req;
      #1;
      check($sformatf("tbl[%0d]", i), {9'b0, gnt_o, gnt_valid_o, hold_flag_o},
            {9'b0, tbl[i].gnt, (tbl[i].gnt != 4'b0), tbl[i].hold});
      model_step(tbl[i].req);
    end

    // owner releases exactly when the hold counter has saturated
    cycle(4'b0010, 1'b1);
    for (int k = 0; k < Q; k++) cycle(4'b0011, 1'b1);
    cycle(4'b0001, 1'b1);
    check("rel_at_expiry_no_preempt", 16'(preempt_o), 16'(1'b0));
    cycle(4'b0001, 1'b1);
    check("rel_at_expiry_handover", 16'(gnt_o), 16'(4'b0001));
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);

`ifdef RIB_ARB_PREEMPT_EN
    // m1 holds forever; m0 joins at ownership cycle 3 and wins at expiry
    cycle(4'b0010, 1'b1);
    for (int k = 0; k < 3; k++) cycle(4'b0010, 1'b1);
    for (int k = 3; k < Q; k++) cycle(4'b0011, 1'b1);
    cycle(4'b0011, 1'b1);
    check("preempt_pulse", 16'(preempt_o), 16'(1'b1));
    cycle(4'b0011, 1'b1);
    check("preempt_new_gnt", 16'({gnt_o, preempt_o, hold_flag_o}), 16'(6'b0001_0_0));
    cycle(4'b0010, 1'b1);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);
`endif

    // asynchronous reset while m3 owns the bus
    cycle(4'b1000, 1'b1);
    cycle(4'b1000, 1'b1);
    #2;
    rst   = 1'b1;
    req_i = 4'b0000;
    #1;
    check("async_rst_gnt", 16'({gnt_o, gnt_valid_o, gnt_id_o}), 16'(7'b0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(4'b1010, 1'b1);
    cycle(4'b1010, 1'b1);
    check("post_rst_ptr0_m1", 16'(gnt_o), 16'(4'b0010));
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);

    // random level-held traffic: each request bit toggles occasionally
    begin
      logic [3:0] r;
      r = 4'b0;
      for (int n = 0; n < 600; n++) begin
        for (int b = 0; b < 4; b++)
          if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
        cycle(r, 1'b1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rib_arbiter.md
# rib_arbiter

Registered round-robin arbiter for the four master ports of the rib bus interconnect. It decides which master (m0 = core data port, m1 = core instruction fetch, m2/m3 = spare or debug) owns the bus. It holds that ownership for the whole transaction and drives the one-hot grant that the interconnect's address/data muxes consume. It also generates the core pipeline stall flag (`hold_flag_o`) when the core's data port is waiting for the bus.

## Interface

**Parameters**
- `N_MASTER`, default 4: number of master ports. Fixed at 4 in this revision.
- `QUANTUM`, default 8: cycles an owner may hold the bus before it can be preempted. Must be ≥ 1. Only used when preemption is compiled in.

**Ports**
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  reset: asynchronous, active-high.
- `req_i`  input  4  per-master request; level-held for the duration of a transaction.
- `gnt_o`  output  4  registered one-hot grant; all-zero when no owner.
- `gnt_id_o`  output  2  index of the current owner; 0 when `gnt_valid_o`=0.
- `gnt_valid_o`  output  1  1 when any grant bit is set.
- `hold_flag_o`  output  1  core stall request: `req_i[0] & ~gnt_o[0]`, combinational from the input and registered state.
- `preempt_o`  output  1  one-cycle pulse in the cycle a grant is revoked by quantum expiry.

## Operation

- **Reset** clears state to IDLE, `gnt_o`=0, `gnt_id_o`=0, `gnt_valid_o`=0, `preempt_o`=0, round-robin pointer `ptr`=0, hold counter `cnt`=0. `hold_flag_o` follows `req_i[0]` during reset.
- **States:**
  - **IDLE**: no owner. If `req_i`≠0, pick a winner and go to BUSY with the grant registered.
  - **BUSY**: the owner keeps the grant while `req_i[owner]`=1.
    - If the owner drops `req_i` and other requests are pending, pick the next owner from the remaining requests. Stay in BUSY and register the new grant.
    - If the owner drops `req_i` and nothing else is pending, go to IDLE with `gnt_o`=0.
- **Pick rule:** the first set bit of `req_i`, masked to exclude the releasing owner, scanning `ptr`, `ptr+1`, … mod 4.
- **On every new grant:** `ptr` ← winner+1 mod 4 (wraps 3→0) and `cnt` ← 0.
- **Hold counter:** `cnt` increments each BUSY cycle and saturates at `QUANTUM`. Its width is clog2(`QUANTUM`+1).
- **Simultaneous events:**
  - Owner release together with quantum expiry is treated as a normal release, so `preempt_o`=0.
  - A request that drops in the same cycle arbitration samples it is not granted.
- **Reset mid-transaction:** the grant drops immediately (asynchronous), and there is no pending state after reset.

## Timing

- Grant latency from IDLE is 1 cycle: `req_i` high before edge *t* gives `gnt_o` valid after edge *t*.
- Handover latency is 0 idle cycles: the owner drops `req_i` before edge *t*, and the new owner's grant is valid after edge *t*.
- The grant is stable for the entire ownership; it changes only on a clock edge or on reset.
- `hold_flag_o` has no register stage. It deasserts in the same cycle `gnt_o[0]` becomes 1.

## Configuration

- **`RIB_ARB_PREEMPT_EN` defined:** in BUSY, if `cnt`==`QUANTUM` and another master requests, the arbiter revokes the owner and grants the pick (owner excluded) at the next edge, with `preempt_o`=1 for that cycle. The preempted master re-competes normally. This option is required when m1 is tied to `req`=1.
- **`RIB_ARB_PREEMPT_EN` not defined:** there is no counter and no preemption, `preempt_o` is tied to 0, and the owner holds the bus until it releases. With m1 tied high, the other masters starve; this is documented as an accepted limitation.

## Structure

- **Package `rib_pkg`:** `RIB_N_MASTER`=4, the master index type (2 bits), the state enum {IDLE, BUSY}, and the default `QUANTUM`.
- **Sub-module `rr_pick`:** combinational round-robin picker. Inputs are the 4-bit request mask and the 2-bit `ptr`. Outputs are a 2-bit winner and a valid bit. It is instantiated once.

## Test plan

1. **Reset values:** assert `rst` with `req_i`=4'b1111, then release `rst`. During reset `gnt_o`=0 and `gnt_valid_o`=0. After the first edge `gnt_o`=4'b0001 (ptr=0).
2. **Round-robin order:** hold `req_i`=4'b1111 and pulse each owner's release for one cycle. Grant order is 0,1,2,3,0, with the pointer wrapping 3→0 and no idle cycles.
3. **Stall flag:** m2 owns the bus, then raise `req_i[0]`. `hold_flag_o`=1 until m2 releases. The next cycle `gnt_o`=4'b0001 and `hold_flag_o`=0.
4. **Preemption (`RIB_ARB_PREEMPT_EN`, `QUANTUM`=8):** hold `req_i[1]`=1 constantly and raise `req_i[0]` at cycle 3 of m1's ownership. `preempt_o` pulses once the counter reaches 8, and `gnt_o`=4'b0001 on the following edge.
5. **Simultaneous release and expiry:** the owner drops `req_i` exactly when `cnt`==`QUANTUM`. `preempt_o`=0 and the grant passes to the pending master.
6. **Reset mid-transaction:** assert `rst` while m3 is granted. `gnt_o` goes to 0 asynchronously and `ptr` is 0 afterwards, so with `req_i`=4'b1010 the first grant is to m1.
